// File: rtl/pwm_multich.sv
// Multi-channel PWM timer: shared prescaler and counter, edge/center-aligned modes,
// shadowed PSC/ARR/CMP registers that commit at period boundaries, period-end interrupt.
module pwm_multich #(
   parameter int CH_NUM    = 4,
   parameter int CNT_WIDTH = 16,
   parameter int PSC_WIDTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cfg_we_i,
   input  logic              cfg_re_i,
   input  logic [7:0]        cfg_addr_i,
   input  logic [31:0]       cfg_wdata_i,
   output logic [31:0]       cfg_rdata_o,
   output logic [CH_NUM-1:0] pwm_o,
   output logic              irq_o
);

   localparam logic [7:0] ADDR_CTRL = 8'h00;
   localparam logic [7:0] ADDR_PSC  = 8'h04;
   localparam logic [7:0] ADDR_ARR  = 8'h08;
   localparam logic [7:0] ADDR_STAT = 8'h0C;
   localparam logic [7:0] ADDR_CNT  = 8'h40;
   localparam int         ADDR_CMP0 = 16;

   logic                 en, mode, irq_en, uif;
   logic [PSC_WIDTH-1:0] psc_sh, psc_act, psc_cnt;
   logic [CNT_WIDTH-1:0] arr_sh, arr_act, cnt;
   logic [CNT_WIDTH-1:0] cmp_sh  [CH_NUM];
   logic [CNT_WIDTH-1:0] cmp_act [CH_NUM];
   logic                 dir_down;

   logic                 wr_ctrl, wr_psc, wr_arr, wr_stat, clr, w1c;
   logic [CH_NUM-1:0]    wr_cmp;
   logic [PSC_WIDTH-1:0] psc_sh_nxt, psc_cnt_nxt;
   logic [CNT_WIDTH-1:0] arr_sh_nxt, cnt_nxt;
   logic [CNT_WIDTH-1:0] cmp_sh_nxt [CH_NUM];
   logic                 dir_nxt, tick, update, load_act;
   logic [CH_NUM-1:0]    pwm_nxt;
   logic [31:0]          rdata_nxt;
   logic                 unused_wdata;

   assign unused_wdata = ^cfg_wdata_i;

   assign wr_ctrl = cfg_we_i && (cfg_addr_i == ADDR_CTRL);
   assign wr_psc  = cfg_we_i && (cfg_addr_i == ADDR_PSC);
   assign wr_arr  = cfg_we_i && (cfg_addr_i == ADDR_ARR);
   assign wr_stat = cfg_we_i && (cfg_addr_i == ADDR_STAT);
   assign clr     = wr_ctrl && cfg_wdata_i[3];
   assign w1c     = wr_stat && cfg_wdata_i[0];

   // Active copies load from the next shadow value so a write landing on the
   // update cycle is taken into the new period.
   assign psc_sh_nxt = wr_psc ? cfg_wdata_i[PSC_WIDTH-1:0] : psc_sh;
   assign arr_sh_nxt = wr_arr ? cfg_wdata_i[CNT_WIDTH-1:0] : arr_sh;

   always_comb begin
      wr_cmp = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         wr_cmp[i]     = cfg_we_i && (cfg_addr_i == 8'(ADDR_CMP0 + 4*i));
         cmp_sh_nxt[i] = wr_cmp[i] ? cfg_wdata_i[CNT_WIDTH-1:0] : cmp_sh[i];
      end
   end

   always_comb begin
      tick        = en && (psc_cnt == psc_act);
      psc_cnt_nxt = '0;
      cnt_nxt     = cnt;
      dir_nxt     = dir_down;
      update      = 1'b0;
      if (!en || clr) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
      end else begin
         psc_cnt_nxt = tick ? '0 : psc_cnt + PSC_WIDTH'(1);
         if (tick) begin
            if (!mode) begin
               if (cnt >= arr_act) begin
                  cnt_nxt = '0;
                  dir_nxt = 1'b0;
                  update  = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_WIDTH'(1);
               end
            end else if (cnt == '0) begin
               // leaving zero upward marks the start of a center-aligned period
               cnt_nxt = (arr_act == '0) ? '0 : CNT_WIDTH'(1);
               dir_nxt = 1'b0;
               update  = 1'b1;
            end else if (cnt >= arr_act || dir_down) begin
               cnt_nxt = cnt - CNT_WIDTH'(1);
               dir_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign load_act = !en || update;

   always_comb begin
      pwm_nxt = '0;
      for (int i = 0; i < CH_NUM; i++)
         pwm_nxt[i] = en && (cnt < cmp_act[i]);
   end

   always_comb begin
      rdata_nxt = '0;
      case (cfg_addr_i)
         ADDR_CTRL: rdata_nxt[2:0]           = {irq_en, mode, en};
         ADDR_PSC:  rdata_nxt[PSC_WIDTH-1:0] = psc_sh;
         ADDR_ARR:  rdata_nxt[CNT_WIDTH-1:0] = arr_sh;
         ADDR_STAT: rdata_nxt[0]             = uif;
         ADDR_CNT:  rdata_nxt[CNT_WIDTH-1:0] = cnt;
         default: begin
            for (int i = 0; i < CH_NUM; i++)
               if (cfg_addr_i == 8'(ADDR_CMP0 + 4*i))
                  rdata_nxt[CNT_WIDTH-1:0] = cmp_sh[i];
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en          <= 1'b0;
         mode        <= 1'b0;
         irq_en      <= 1'b0;
         uif         <= 1'b0;
         psc_sh      <= '0;
         psc_act     <= '0;
         psc_cnt     <= '0;
         arr_sh      <= '0;
         arr_act     <= '0;
         cnt         <= '0;
         dir_down    <= 1'b0;
         pwm_o       <= '0;
         irq_o       <= 1'b0;
         cfg_rdata_o <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            cmp_sh[i]  <= '0;
            cmp_act[i] <= '0;
         end
      end else begin
         if (wr_ctrl)
            {irq_en, mode, en} <= cfg_wdata_i[2:0];
         psc_sh   <= psc_sh_nxt;
         arr_sh   <= arr_sh_nxt;
         if (load_act) begin
            psc_act <= psc_sh_nxt;
            arr_act <= arr_sh_nxt;
         end
         psc_cnt  <= psc_cnt_nxt;
         cnt      <= cnt_nxt;
         dir_down <= dir_nxt;
         uif      <= update || (uif && !w1c);
         pwm_o    <= pwm_nxt;
         irq_o    <= irq_en && uif;
         if (cfg_re_i)
            cfg_rdata_o <= rdata_nxt;
         for (int i = 0; i < CH_NUM; i++) begin
            cmp_sh[i] <= cmp_sh_nxt[i];
            if (load_act)
               cmp_act[i] <= cmp_sh_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_multich.sv
// Self-checking bench for pwm_multich: directed register/interrupt/clear cases plus
// randomized PWM segments compared against an arithmetic period model.
module tb_pwm_multich;
   localparam int CH = 4;
   localparam int CW = 16;
   localparam int PW = 16;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          cfg_we_i = 1'b0;
   logic          cfg_re_i = 1'b0;
   logic [7:0]    cfg_addr_i = '0;
   logic [31:0]   cfg_wdata_i = '0;
   logic [31:0]   cfg_rdata_o;
   logic [CH-1:0] pwm_o;
   logic          irq_o;

   pwm_multich #(.CH_NUM(CH), .CNT_WIDTH(CW), .PSC_WIDTH(PW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_we_i(cfg_we_i), .cfg_re_i(cfg_re_i),
      .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
      .pwm_o(pwm_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   logic [31:0] rv;

   // model state for one segment: tick count n = cycles_since_enable / (psc+1)
   int m_mode, m_psc, m_arr0, m_arr1, m_cmp1;
   int m_cmp [CH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
      step();
      cfg_we_i = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      cfg_re_i = 1'b1; cfg_addr_i = a;
      step();
      cfg_re_i = 1'b0;
      d = cfg_rdata_o;
   endtask

   function automatic int ticks_before(int j);
      return j / (m_psc + 1);
   endfunction

   function automatic int cnt_at(int j);
      int n, t1, p;
      n  = ticks_before(j);
      t1 = m_arr0 + 1;
      if (m_mode == 0)
         return (n < t1) ? n : (n - t1) % (m_arr1 + 1);
      if (m_arr0 == 0)
         return 0;
      p = n % (2 * m_arr0);
      return (p <= m_arr0) ? p : 2 * m_arr0 - p;
   endfunction

   function automatic int cmp_at(int j, int ch);
      if (m_mode == 0 && ch == 0 && ticks_before(j) >= m_arr0 + 1)
         return m_cmp1;
      return m_cmp[ch];
   endfunction

   // Configure while disabled, enable, then check every cycle; optionally write CMP0
   // at cycle w and ARR at w+1 during the first edge-mode period.
   task automatic run_seg(input int mode, input int psc, input int arr0,
                          input int c0, input int c1, input int c2, input int c3,
                          input int irq_en, input int mid, input int w,
                          input int arr1, input int cmp1, input int n);
      int ku;
      logic rd_ok;
      logic [CH-1:0] pe;
      m_mode = mode; m_psc = psc; m_arr0 = arr0;
      m_cmp[0] = c0; m_cmp[1] = c1; m_cmp[2] = c2; m_cmp[3] = c3;
      m_arr1 = mid ? arr1 : arr0;
      m_cmp1 = mid ? cmp1 : c0;
      wr(8'h00, 32'h0);
      wr(8'h04, 32'(psc));
      wr(8'h08, 32'(arr0));
      for (int ch = 0; ch < CH; ch++)
         wr(8'(16 + 4*ch), 32'(m_cmp[ch]));
      wr(8'h0C, 32'h1);
      cfg_we_i = 1'b1; cfg_addr_i = 8'h00;
      cfg_wdata_i = 32'(1 + 2*mode + 4*irq_en);
      step();
      cfg_we_i = 1'b0;
      ku = mode ? psc : (arr0 + 1) * (psc + 1) - 1;
      rd_ok = 1'b0;
      for (int k = 0; k < n; k++) begin
         for (int ch = 0; ch < CH; ch++)
            pe[ch] = (k > 0) && (cnt_at(k-1) < cmp_at(k-1, ch));
         chk("pwm", 32'(pwm_o), 32'(pe));
         chk("irq", 32'(irq_o), 32'((irq_en != 0) && (k >= ku + 2)));
         if (rd_ok)
            chk("cnt", cfg_rdata_o, 32'(cnt_at(k-1)));
         cfg_we_i = 1'b0; cfg_re_i = 1'b0;
         if (mid != 0 && k == w) begin
            cfg_we_i = 1'b1; cfg_addr_i = 8'h10; cfg_wdata_i = 32'(cmp1);
         end else if (mid != 0 && k == w + 1) begin
            cfg_we_i = 1'b1; cfg_addr_i = 8'h08; cfg_wdata_i = 32'(arr1);
         end else begin
            cfg_re_i = 1'b1; cfg_addr_i = 8'h40;
         end
         rd_ok = cfg_re_i;
         step();
      end
      cfg_we_i = 1'b1; cfg_re_i = 1'b0; cfg_addr_i = 8'h00; cfg_wdata_i = 32'h0;
      step();
      cfg_we_i = 1'b0;
      step();
      chk("dis_pwm", 32'(pwm_o), 32'h0);
      rd(8'h40, rv);
      chk("dis_cnt", rv, 32'h0);
   endtask

   initial begin
      int mode, psc, arr, irq, mid, w, arr1, cmp1, ku;
      int c [CH];
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_pwm", 32'(pwm_o), 32'h0);
      chk("rst_irq", 32'(irq_o), 32'h0);
      chk("rst_rdata", cfg_rdata_o, 32'h0);
      rst_n_i = 1'b1;
      step();

      rd(8'h00, rv);            chk("rst_ctrl", rv, 32'h0);
      wr(8'h3C, 32'hFFFF_FFFF);
      rd(8'h3C, rv);            chk("unmapped", rv, 32'h0);
      wr(8'h20, 32'h5);
      rd(8'h20, rv);            chk("cmp4_rd", rv, 32'h0);
      rd(8'h10, rv);            chk("cmp0_alias", rv, 32'h0);
      wr(8'h08, 32'hFFFF_FFFF);
      rd(8'h08, rv);            chk("arr_trunc", rv, 32'h0000_FFFF);
      wr(8'h04, 32'h0001_2345);
      rd(8'h04, rv);            chk("psc_trunc", rv, 32'h0000_2345);
      wr(8'h00, 32'hE);
      rd(8'h00, rv);            chk("ctrl_rd", rv, 32'h6);
      wr(8'h00, 32'h0);
      wr(8'h08, 32'h7);
      cfg_we_i = 1'b1; cfg_re_i = 1'b1; cfg_addr_i = 8'h08; cfg_wdata_i = 32'h3;
      step();
      cfg_we_i = 1'b0; cfg_re_i = 1'b0;
      chk("rw_collide", cfg_rdata_o, 32'h7);
      rd(8'h08, rv);            chk("rw_after", rv, 32'h3);

      run_seg(0, 0, 9, 3, 0, 10, 5, 1, 0, 0, 0, 0, 40);
      run_seg(1, 1, 4, 2, 0, 5, 3, 1, 0, 0, 0, 0, 50);
      run_seg(0, 0, 9, 3, 0, 10, 5, 0, 1, 5, 9, 7, 40);
      run_seg(0, 0, 9, 3, 1, 2, 4, 0, 1, 5, 4, 3, 40);
      run_seg(0, 0, 5, 2, 2, 2, 2, 1, 1, 4, 3, 1, 40);

      for (int s = 0; s < 8; s++) begin
         mode = int'($urandom_range(0, 1));
         psc  = int'($urandom_range(0, 3));
         arr  = mode ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 9));
         for (int ch = 0; ch < CH; ch++)
            c[ch] = int'($urandom_range(0, arr + 2));
         irq  = int'($urandom_range(0, 1));
         ku   = (arr + 1) * (psc + 1) - 1;
         mid  = (mode == 0 && ku >= 1) ? int'($urandom_range(0, 1)) : 0;
         w    = mid ? int'($urandom_range(0, ku - 1)) : 0;
         arr1 = int'($urandom_range(0, 9));
         cmp1 = int'($urandom_range(0, arr1 + 2));
         run_seg(mode, psc, arr, c[0], c[1], c[2], c[3], irq, mid, w, arr1, cmp1, 70);
      end

      // interrupt: ARR=3, PSC=0 -> wrap ticks at k=3,7,11
      wr(8'h00, 32'h0); wr(8'h04, 32'h0); wr(8'h08, 32'h3);
      wr(8'h10, 32'h1); wr(8'h0C, 32'h1);
      cfg_we_i = 1'b1; cfg_addr_i = 8'h00; cfg_wdata_i = 32'h5;
      step();
      cfg_we_i = 1'b0;
      repeat (4) step();
      chk("irq_pre", 32'(irq_o), 32'h0);
      step();
      chk("irq_rise", 32'(irq_o), 32'h1);
      cfg_we_i = 1'b1; cfg_addr_i = 8'h0C; cfg_wdata_i = 32'h1;
      step();
      cfg_we_i = 1'b0;
      step();
      chk("irq_w1c", 32'(irq_o), 32'h0);
      cfg_we_i = 1'b1; cfg_addr_i = 8'h0C; cfg_wdata_i = 32'h1;
      step();
      cfg_we_i = 1'b0;
      step();
      chk("irq_set_wins", 32'(irq_o), 32'h1);
      rd(8'h0C, rv);            chk("uif_set_wins", rv, 32'h1);

      // CLR at cnt=6 with ARR=9: no wrap, so UIF must stay clear
      wr(8'h00, 32'h0); wr(8'h08, 32'h9); wr(8'h10, 32'h3); wr(8'h0C, 32'h1);
      cfg_we_i = 1'b1; cfg_addr_i = 8'h00; cfg_wdata_i = 32'h5;
      step();
      cfg_we_i = 1'b0;
      repeat (6) step();
      cfg_we_i = 1'b1; cfg_addr_i = 8'h00; cfg_wdata_i = 32'hD;
      step();
      cfg_we_i = 1'b0;
      cfg_re_i = 1'b1; cfg_addr_i = 8'h40;
      step();
      chk("clr_cnt", cfg_rdata_o, 32'h0);
      step();
      chk("clr_count_on", cfg_rdata_o, 32'h1);
      cfg_addr_i = 8'h0C;
      step();
      step();
      cfg_re_i = 1'b0;
      chk("clr_no_uif", cfg_rdata_o, 32'h0);
      chk("clr_no_irq", 32'(irq_o), 32'h0);
      rd(8'h00, rv);            chk("ctrl_clr_rd0", rv, 32'h5);

      // async reset mid-period with outputs active
      wr(8'h00, 32'h0); wr(8'h08, 32'h3); wr(8'h10, 32'h5); wr(8'h0C, 32'h1);
      wr(8'h00, 32'h5);
      repeat (10) step();
      chk("pre_rst_pwm0", 32'(pwm_o[0]), 32'h1);
      chk("pre_rst_irq", 32'(irq_o), 32'h1);
      rd(8'h08, rv);            chk("pre_rst_rd", rv, 32'h3);
      #2 rst_n_i = 1'b0;
      #1;
      chk("arst_pwm", 32'(pwm_o), 32'h0);
      chk("arst_irq", 32'(irq_o), 32'h0);
      chk("arst_rdata", cfg_rdata_o, 32'h0);
      step();
      rst_n_i = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
